aes_xor_stream_engine: RTL and testbench

AES_XOR_STREAM_ENGINE -- requirements
Module: aes_xor_stream_engine

---
 rtl/aes_xor_stream_engine.sv | 189 ++++++++++++++++++
 tb/tb_aes_xor_stream_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_xor_stream_engine.sv
// aes_xor_stream_engine
// Block-oriented XOR stream engine. It loads a BLOCK_W-bit key from the
// key stream, then for each of len blocks it gathers WORDS input words,
// XORs the block with the key and emits the result word by word. In
// chained mode (mode=1), each emitted block becomes the key for the next.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, clear_i      job start (taken only in IDLE), synchronous abort
//   mode_i, len_i         key mode and block count, captured on start
//   key_data_i/valid/ready    key word stream (engine is the sink)
//   in_data_i/valid/ready     input word stream (engine is the sink)
//   out_data_o/valid/ready/strb  output word stream (engine is the source)
//   busy_o, done_o        not-idle flag, one-cycle completion pulse
//   blk_cnt_o             blocks fully emitted in the current job
module aes_xor_stream_engine #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int LEN_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic                mode_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [DATA_W-1:0]   key_data_i,
  input  logic                key_valid_i,
  output logic                key_ready_o,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W/8-1:0] out_strb_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [LEN_W-1:0]    blk_cnt_o
);

  localparam int WORDS = BLOCK_W / DATA_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_GATHER,
    S_XOR,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                       state;
  logic [CNT_W-1:0]             word_cnt;
  logic [LEN_W-1:0]             len_q;
  logic                         mode_q;
  logic [WORDS-1:0][DATA_W-1:0] key_q;
  logic [WORDS-1:0][DATA_W-1:0] blk_p0;
  logic [WORDS-1:0][DATA_W-1:0] res_p1;

  logic [CNT_W-1:0] word_nxt;
  logic [LEN_W-1:0] blk_cnt_nxt;
  logic             key_xfer;
  logic             in_xfer;
  logic             out_xfer;

  assign word_nxt    = word_cnt + CNT_W'(1);
  assign blk_cnt_nxt = blk_cnt_o + LEN_W'(1);
  assign key_xfer    = key_valid_i & key_ready_o;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  // All handshake and status outputs are registers set on the transition
  // into the state that owns them, so they change only at clock edges.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      blk_p0      <= '0;
      res_p1      <= '0;
      key_ready_o <= 1'b0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_strb_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      blk_cnt_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            mode_q    <= mode_i;
            blk_cnt_o <= '0;
            word_cnt  <= '0;
            busy_o    <= 1'b1;
            if (len_i != '0) begin
              key_ready_o <= 1'b1;
              state       <= S_LOAD_KEY;
            end else begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_LOAD_KEY: begin
          if (key_xfer) begin
            key_q[word_cnt] <= key_data_i;
            if (word_cnt == LAST_WORD) begin
              word_cnt    <= '0;
              key_ready_o <= 1'b0;
              in_ready_o  <= 1'b1;
              state       <= S_GATHER;
            end else begin
              word_cnt <= word_nxt;
            end
          end
        end

        // Stage p0: input words collected into the block register
        S_GATHER: begin
          if (in_xfer) begin
            blk_p0[word_cnt] <= in_data_i;
            if (word_cnt == LAST_WORD) begin
              word_cnt   <= '0;
              in_ready_o <= 1'b0;
              state      <= S_XOR;
            end else begin
              word_cnt <= word_nxt;
            end
          end
        end

        // Stage p1: block XOR key registered; word 0 is preloaded so the
        // first output word is valid on entry to EMIT
        S_XOR: begin
          res_p1      <= blk_p0 ^ key_q;
          out_data_o  <= blk_p0[0] ^ key_q[0];
          out_valid_o <= 1'b1;
          out_strb_o  <= '1;
          state       <= S_EMIT;
        end

        S_EMIT: begin
          if (out_xfer) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt    <= '0;
              out_valid_o <= 1'b0;
              out_data_o  <= '0;
              out_strb_o  <= '0;
              blk_cnt_o   <= blk_cnt_nxt;
              if (mode_q) begin
                key_q <= res_p1;
              end
              if (blk_cnt_nxt == len_q) begin
                done_o <= 1'b1;
                state  <= S_DONE;
              end else begin
                in_ready_o <= 1'b1;
                state      <= S_GATHER;
              end
            end else begin
              word_cnt   <= word_nxt;
              out_data_o <= res_p1[word_nxt];
            end
          end
        end

        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_xor_stream_engine.sv
// tb_aes_xor_stream_engine
// Self-checking bench for aes_xor_stream_engine (DATA_W=32, BLOCK_W=128).
// Expected output words come from a block-level reference model: each
// output block is input XOR current key, and in chained mode the key
// becomes the previous output block.
module tb_aes_xor_stream_engine;

  localparam int DATA_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int LEN_W   = 16;
  localparam int WORDS   = BLOCK_W / DATA_W;

  logic               clk;
  logic               rst_i;
  logic               start_i;
  logic               clear_i;
  logic               mode_i;
  logic [LEN_W-1:0]   len_i;
  logic [DATA_W-1:0]  key_data_i;
  logic               key_valid_i;
  logic               key_ready_o;
  logic [DATA_W-1:0]  in_data_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [DATA_W-1:0]  out_data_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [DATA_W/8-1:0] out_strb_o;
  logic               busy_o;
  logic               done_o;
  logic [LEN_W-1:0]   blk_cnt_o;

  aes_xor_stream_engine #(
    .DATA_W (DATA_W),
    .BLOCK_W(BLOCK_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .clear_i    (clear_i),
    .mode_i     (mode_i),
    .len_i      (len_i),
    .key_data_i (key_data_i),
    .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_strb_o (out_strb_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .blk_cnt_o  (blk_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] key_words[$];
  logic [DATA_W-1:0] in_words[$];
  logic [DATA_W-1:0] exp_q[$];
  int                lat_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: whole-block XOR with optional key chaining.
  task automatic build_expected(input bit mode, input int nblk);
    logic [DATA_W-1:0] kc[WORDS];
    logic [DATA_W-1:0] o[WORDS];
    exp_q.delete();
    for (int k = 0; k < WORDS; k++) kc[k] = key_words[k];
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < WORDS; k++) begin
        o[k] = in_words[b*WORDS + k] ^ kc[k];
        exp_q.push_back(o[k]);
      end
      if (mode) for (int k = 0; k < WORDS; k++) kc[k] = o[k];
    end
  endtask

  task automatic rand_words(input int nblk);
    key_words.delete();
    in_words.delete();
    for (int k = 0; k < WORDS; k++) key_words.push_back($urandom);
    for (int i = 0; i < nblk*WORDS; i++) in_words.push_back($urandom);
  endtask

  task automatic feed_key();
    int idx = 0;
    int guard = 0;
    while (idx < WORDS && guard < 2000) begin
      @(negedge clk);
      guard++;
      key_data_i  = key_words[idx];
      key_valid_i = ($urandom_range(3) != 0);
      if (key_valid_i && key_ready_o) idx++;
    end
    @(negedge clk);
    key_valid_i = 1'b0;
    if (idx < WORDS) check_eq("key_feed_timeout", 64'(idx), 64'(WORDS));
  endtask

  task automatic feed_in(input int nblk);
    int idx = 0;
    int guard = 0;
    while (idx < nblk*WORDS && guard < 5000) begin
      @(negedge clk);
      guard++;
      in_data_i  = in_words[idx];
      in_valid_i = ($urandom_range(3) != 0);
      if (in_valid_i && in_ready_o) begin
        if (idx % WORDS == WORDS-1) lat_q.push_back(cyc);
        idx++;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    if (idx < nblk*WORDS) check_eq("in_feed_timeout", 64'(idx), 64'(nblk*WORDS));
  endtask

  task automatic monitor(input int nblk, input bit stall);
    int acc = 0;
    int stall_n = 0;
    int guard = 0;
    int c;
    bit prev_v = 1'b0;
    bit prev_r = 1'b0;
    bit done_seen = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    logic [DATA_W-1:0] e;
    while (!done_seen && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (prev_v && !prev_r) begin
        check_eq("hold_valid", 64'(out_valid_o), 64'(1));
        check_eq("hold_data", 64'(out_data_o), 64'(prev_d));
      end
      if (out_valid_o && !prev_v) begin
        check_eq("lat_pending", 64'(lat_q.size() > 0), 64'(1));
        if (lat_q.size() > 0) begin
          c = lat_q.pop_front();
          check_eq("latency", 64'(cyc - c), 64'(2));
        end
      end
      check_eq("strb", 64'(out_strb_o), out_valid_o ? 64'hF : 64'h0);
      if (stall) begin
        if (out_valid_o && acc == 1 && stall_n < 3) begin
          out_ready_i = 1'b0;
          stall_n++;
        end else begin
          out_ready_i = 1'b1;
        end
      end else begin
        out_ready_i = ($urandom_range(3) != 0);
      end
      if (out_valid_o && out_ready_i) begin
        check_eq("exp_avail", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_word", 64'(out_data_o), 64'(e));
        end
        acc++;
      end
      if (done_o) begin
        done_seen = 1'b1;
        check_eq("blk_cnt_done", 64'(blk_cnt_o), 64'(nblk));
        check_eq("exp_drained", 64'(exp_q.size()), 64'(0));
      end
      prev_v = out_valid_o;
      prev_r = out_ready_i;
      prev_d = out_data_o;
    end
    out_ready_i = 1'b0;
    if (!done_seen) begin
      check_eq("done_timeout", 64'(done_seen), 64'(1));
    end else begin
      @(negedge clk);
      check_eq("done_one_cycle", 64'(done_o), 64'(0));
      check_eq("idle_after_done", 64'(busy_o), 64'(0));
      check_eq("blk_cnt_hold", 64'(blk_cnt_o), 64'(nblk));
    end
  endtask

  task automatic start_job(input bit mode, input int nblk);
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = mode;
    len_i   = LEN_W'(nblk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_job(input bit mode, input int nblk, input bit stall);
    build_expected(mode, nblk);
    lat_q.delete();
    start_job(mode, nblk);
    check_eq("busy_after_start", 64'(busy_o), 64'(1));
    check_eq("key_ready_after_start", 64'(key_ready_o), 64'(1));
    fork
      begin
        feed_key();
        feed_in(nblk);
      end
      monitor(nblk, stall);
    join
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid_o), 64'(0));
    check_eq({tag, "_out_data"},  64'(out_data_o),  64'(0));
    check_eq({tag, "_out_strb"},  64'(out_strb_o),  64'(0));
    check_eq({tag, "_key_ready"}, 64'(key_ready_o), 64'(0));
    check_eq({tag, "_in_ready"},  64'(in_ready_o),  64'(0));
    check_eq({tag, "_busy"},      64'(busy_o),      64'(0));
    check_eq({tag, "_done"},      64'(done_o),      64'(0));
    check_eq({tag, "_blk_cnt"},   64'(blk_cnt_o),   64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    int acc;
    bit bad;
    logic [DATA_W-1:0] e;

    rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; mode_i = 1'b0; len_i = '0;
    key_data_i = '0; key_valid_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b0;

    // Directed: static key, one block
    key_words = '{32'h1, 32'h2, 32'h3, 32'h4};
    in_words  = '{32'h10, 32'h20, 32'h30, 32'h40};
    run_job(1'b0, 1, 1'b0);

    // Directed: chained key, two blocks
    key_words = '{32'h0F, 32'h0F, 32'h0F, 32'h0F};
    in_words  = '{32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_job(1'b1, 2, 1'b0);

    // Back-pressure for 3 cycles on output word 1
    rand_words(2);
    run_job(1'b0, 2, 1'b1);

    // Zero-length job
    start_job(1'b0, 0);
    check_eq("len0_done", 64'(done_o), 64'(1));
    check_eq("len0_busy", 64'(busy_o), 64'(1));
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (key_ready_o || in_ready_o || out_valid_o) bad = 1'b1;
    end
    check_eq("len0_no_handshake", 64'(bad), 64'(0));
    check_eq("len0_idle", 64'(busy_o), 64'(0));
    check_eq("len0_blk_cnt", 64'(blk_cnt_o), 64'(0));

    // Clear after two input words of a block
    rand_words(2);
    start_job(1'b0, 2);
    feed_key();
    n = 0;
    g = 0;
    while (n < 2 && g < 1000) begin
      @(negedge clk);
      g++;
      in_valid_i = 1'b1;
      in_data_i  = in_words[n];
      if (in_ready_o) n++;
    end
    check_eq("clear_words_fed", 64'(n), 64'(2));
    @(negedge clk);
    in_valid_i = 1'b0;
    clear_i    = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check_all_zero("clear");
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_o || done_o || busy_o) bad = 1'b1;
    end
    check_eq("clear_quiet", 64'(bad), 64'(0));
    rand_words(2);
    run_job(1'b0, 2, 1'b0);

    // Reset while output word 2 is presented
    rand_words(1);
    build_expected(1'b0, 1);
    start_job(1'b0, 1);
    feed_key();
    feed_in(1);
    out_ready_i = 1'b1;
    acc = 0;
    g = 0;
    while (g < 200) begin
      @(negedge clk);
      g++;
      if (out_valid_o) begin
        if (acc == 2) break;
        e = exp_q.pop_front();
        check_eq("pre_rst_word", 64'(out_data_o), 64'(e));
        acc++;
      end
    end
    check_eq("reached_word2", 64'(acc), 64'(2));
    rst_i       = 1'b1;
    out_ready_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    check_all_zero("midjob_rst");
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_o || done_o || busy_o) bad = 1'b1;
    end
    check_eq("rst_quiet", 64'(bad), 64'(0));
    exp_q.delete();
    rand_words(1);
    run_job(1'b0, 1, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      int nb;
      nb = $urandom_range(4, 1);
      rand_words(nb);
      run_job(1'($urandom_range(1)), nb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
